// File: rtl/ring_counter_n_if.sv
// Control and status bundle for ring_counter_n: the sequencer's driver uses the
// master view, the counter itself uses the slave view.
interface ring_counter_n_if #(
    parameter int N = 4
);
    logic         CE;
    logic         DIR;
    logic         LOAD;
    logic [N-1:0] DI;
    logic [N-1:0] O;
    logic         WRAP;
    logic         ERR;

    modport master (
        output CE, DIR, LOAD, DI,
        input  O, WRAP, ERR
    );

    modport slave (
        input  CE, DIR, LOAD, DI,
        output O, WRAP, ERR
    );
endinterface

// File: rtl/ring_counter_n.sv
// N-bit ring (one-hot) or Johnson (thermometer) sequencer with enable, direction,
// parallel load and recovery to INIT from illegal states on an enabled step.
module ring_counter_n #(
    parameter int           N    = 4,
    parameter int           MODE = 0,
    parameter logic [N-1:0] INIT = {{(N-1){1'b0}}, 1'b1}
) (
    input logic              CLK,
    input logic              RESET,
    ring_counter_n_if.slave  bus
);
    logic [N-1:0] o_q, o_d;
    logic         wrap_q, wrap_d;
    logic         err_q, err_d;

    logic [N-1:0] shift_left, shift_right, shifted;
    logic         fb_left, fb_right;
    logic         legal;
    int           ones_cnt;
    int           edge_cnt;

    // Johnson feedback inverts the bit wrapping around; ring feedback passes it through.
    always_comb begin
        fb_left     = (MODE == 1) ? ~o_q[N-1] : o_q[N-1];
        fb_right    = (MODE == 1) ? ~o_q[0]   : o_q[0];
        shift_left  = {o_q[N-2:0], fb_left};
        shift_right = {fb_right, o_q[N-1:1]};
        shifted     = bus.DIR ? shift_right : shift_left;
    end

    // A legal Johnson word has at most one boundary between adjacent differing bits.
    always_comb begin
        ones_cnt = $countones(o_q);
        edge_cnt = $countones(o_q[N-1:1] ^ o_q[N-2:0]);
        legal    = (MODE == 1) ? (edge_cnt <= 1) : (ones_cnt == 1);
    end

    always_comb begin
        o_d    = o_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (bus.LOAD) begin
            o_d = bus.DI;
        end else if (bus.CE) begin
            if (legal) begin
                o_d    = shifted;
                wrap_d = (shifted == INIT);
            end else begin
                o_d   = INIT;
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            o_q    <= INIT;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            o_q    <= o_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign bus.O    = o_q;
    assign bus.WRAP = wrap_q;
    assign bus.ERR  = err_q;
endmodule

// File: tb/tb_ring_counter_n.sv
// Directed bench for ring_counter_n: 4-bit ring, 4-bit Johnson and 8-bit ring
// instances, each driven in turn through its own interface.
module tb_ring_counter_n;
    logic clk;
    logic rst_r4, rst_j4, rst_r8;
    int   pass_count;
    int   total_count;

    ring_counter_n_if #(.N(4)) bus_r4 ();
    ring_counter_n_if #(.N(4)) bus_j4 ();
    ring_counter_n_if #(.N(8)) bus_r8 ();

    ring_counter_n #(.N(4), .MODE(0), .INIT(4'b0001)) dut_r4 (
        .CLK(clk), .RESET(rst_r4), .bus(bus_r4)
    );
    ring_counter_n #(.N(4), .MODE(1), .INIT(4'b0000)) dut_j4 (
        .CLK(clk), .RESET(rst_j4), .bus(bus_j4)
    );
    ring_counter_n #(.N(8), .MODE(0), .INIT(8'b0000_0001)) dut_r8 (
        .CLK(clk), .RESET(rst_r8), .bus(bus_r8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] exp_ring_left  [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] exp_ring_right [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [3:0] exp_johnson    [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                       4'b1110, 4'b1100, 4'b1000, 4'b0000};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_count++;
        assert (obs === exp) pass_count++;
        else $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check_flag(input string tag, input logic obs, input logic exp);
        total_count++;
        assert (obs === exp) pass_count++;
        else $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    initial begin
        logic [7:0] e8;
        pass_count  = 0;
        total_count = 0;
        rst_r4 = 1'b1; rst_j4 = 1'b1; rst_r8 = 1'b1;
        bus_r4.CE = 1'b0; bus_r4.DIR = 1'b0; bus_r4.LOAD = 1'b0; bus_r4.DI = 4'b0000;
        bus_j4.CE = 1'b0; bus_j4.DIR = 1'b0; bus_j4.LOAD = 1'b0; bus_j4.DI = 4'b0000;
        bus_r8.CE = 1'b0; bus_r8.DIR = 1'b0; bus_r8.LOAD = 1'b0; bus_r8.DI = 8'h00;
        tick();
        tick();
        rst_r4 = 1'b0; rst_j4 = 1'b0; rst_r8 = 1'b0;

        check_output("reset_r4_o", {4'b0000, bus_r4.O}, 8'b0000_0001);
        check_flag("reset_r4_wrap", bus_r4.WRAP, 1'b0);
        check_flag("reset_r4_err", bus_r4.ERR, 1'b0);
        check_output("reset_j4_o", {4'b0000, bus_j4.O}, 8'b0000_0000);
        check_output("reset_r8_o", bus_r8.O, 8'b0000_0001);

        // ring, shift left through a full period
        bus_r4.CE = 1'b1; bus_r4.DIR = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_output("ring_left_o", {4'b0000, bus_r4.O}, {4'b0000, exp_ring_left[i]});
            check_flag("ring_left_wrap", bus_r4.WRAP, i == 3);
        end

        // ring, shift right through a full period
        bus_r4.DIR = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_output("ring_right_o", {4'b0000, bus_r4.O}, {4'b0000, exp_ring_right[i]});
            check_flag("ring_right_wrap", bus_r4.WRAP, i == 3);
        end

        // direction flips take effect on the very next edge
        tick();
        check_output("dir_flip_r", {4'b0000, bus_r4.O}, 8'b0000_1000);
        bus_r4.DIR = 1'b0;
        tick();
        check_output("dir_flip_l", {4'b0000, bus_r4.O}, 8'b0000_0001);
        check_flag("dir_flip_wrap", bus_r4.WRAP, 1'b1);
        tick();
        check_output("dir_flip_l2", {4'b0000, bus_r4.O}, 8'b0000_0010);
        check_flag("dir_flip_wrap2", bus_r4.WRAP, 1'b0);
        bus_r4.CE = 1'b0;

        // Johnson left through 2N states, then one step right from INIT
        bus_j4.CE = 1'b1; bus_j4.DIR = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_output("johnson_left_o", {4'b0000, bus_j4.O}, {4'b0000, exp_johnson[i]});
            check_flag("johnson_left_wrap", bus_j4.WRAP, i == 7);
        end
        bus_j4.DIR = 1'b1;
        tick();
        check_output("johnson_right_o", {4'b0000, bus_j4.O}, 8'b0000_1000);
        bus_j4.CE = 1'b0;

        // ring: illegal load holds while disabled, recovers on enabled step
        bus_r4.LOAD = 1'b1; bus_r4.DI = 4'b0110;
        tick();
        bus_r4.LOAD = 1'b0;
        check_output("ring_load_o", {4'b0000, bus_r4.O}, 8'b0000_0110);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("ring_hold_o", {4'b0000, bus_r4.O}, 8'b0000_0110);
            check_flag("ring_hold_err", bus_r4.ERR, 1'b0);
        end
        bus_r4.CE = 1'b1;
        tick();
        check_output("ring_fix_o", {4'b0000, bus_r4.O}, 8'b0000_0001);
        check_flag("ring_fix_err", bus_r4.ERR, 1'b1);
        check_flag("ring_fix_wrap", bus_r4.WRAP, 1'b0);
        tick();
        check_output("ring_after_fix_o", {4'b0000, bus_r4.O}, 8'b0000_0010);
        check_flag("ring_after_fix_err", bus_r4.ERR, 1'b0);
        bus_r4.CE = 1'b0;

        // Johnson: same recovery sequence with a non-thermometer word
        bus_j4.LOAD = 1'b1; bus_j4.DI = 4'b0101;
        tick();
        bus_j4.LOAD = 1'b0;
        check_output("johnson_load_o", {4'b0000, bus_j4.O}, 8'b0000_0101);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("johnson_hold_o", {4'b0000, bus_j4.O}, 8'b0000_0101);
            check_flag("johnson_hold_err", bus_j4.ERR, 1'b0);
        end
        bus_j4.CE = 1'b1; bus_j4.DIR = 1'b0;
        tick();
        check_output("johnson_fix_o", {4'b0000, bus_j4.O}, 8'b0000_0000);
        check_flag("johnson_fix_err", bus_j4.ERR, 1'b1);
        check_flag("johnson_fix_wrap", bus_j4.WRAP, 1'b0);
        tick();
        check_output("johnson_after_fix_o", {4'b0000, bus_j4.O}, 8'b0000_0001);
        check_flag("johnson_after_fix_err", bus_j4.ERR, 1'b0);
        bus_j4.CE = 1'b0;

        // LOAD beats CE (a right shift from 0010 would have wrapped to 0001)
        bus_r4.CE = 1'b1; bus_r4.DIR = 1'b1; bus_r4.LOAD = 1'b1; bus_r4.DI = 4'b0100;
        tick();
        check_output("load_vs_ce_o", {4'b0000, bus_r4.O}, 8'b0000_0100);
        check_flag("load_vs_ce_wrap", bus_r4.WRAP, 1'b0);
        // RESET beats LOAD
        rst_r4 = 1'b1; bus_r4.DI = 4'b1000;
        tick();
        check_output("reset_vs_load_o", {4'b0000, bus_r4.O}, 8'b0000_0001);
        rst_r4 = 1'b0; bus_r4.LOAD = 1'b0; bus_r4.DIR = 1'b0;

        // reset held two cycles mid-sequence, then counting resumes
        tick();
        tick();
        check_output("pre_reset_o", {4'b0000, bus_r4.O}, 8'b0000_0100);
        rst_r4 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_output("mid_reset_o", {4'b0000, bus_r4.O}, 8'b0000_0001);
            check_flag("mid_reset_wrap", bus_r4.WRAP, 1'b0);
            check_flag("mid_reset_err", bus_r4.ERR, 1'b0);
        end
        rst_r4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_output("resume_o", {4'b0000, bus_r4.O}, {4'b0000, exp_ring_left[i]});
            check_flag("resume_wrap", bus_r4.WRAP, i == 3);
        end
        bus_r4.CE = 1'b0;

        // 8-bit ring: full left period, one right step, illegal-load recovery
        bus_r8.CE = 1'b1; bus_r8.DIR = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            e8 = 8'h01 << ((i + 1) % 8);
            check_output("r8_left_o", bus_r8.O, e8);
            check_flag("r8_left_wrap", bus_r8.WRAP, i == 7);
        end
        bus_r8.DIR = 1'b1;
        tick();
        check_output("r8_right_o", bus_r8.O, 8'b1000_0000);
        bus_r8.LOAD = 1'b1; bus_r8.DI = 8'b0000_0011;
        tick();
        check_output("r8_load_o", bus_r8.O, 8'b0000_0011);
        bus_r8.LOAD = 1'b0;
        tick();
        check_output("r8_fix_o", bus_r8.O, 8'b0000_0001);
        check_flag("r8_fix_err", bus_r8.ERR, 1'b1);
        bus_r8.CE = 1'b0;

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end
endmodule
